// File: rtl/ld_exec_sched_pkg.sv
// Shared definitions for the load execution sequencer: reservation-station
// tag map, sequencer state encoding and a small ready-bus helper.
package ld_exec_sched_pkg;

    // Reservation-station tags used across the out-of-order core
    typedef enum logic [3:0] {
        TAG_NOTAG  = 4'd0,
        TAG_ADD_1  = 4'd1,
        TAG_ADD_2  = 4'd2,
        TAG_ADD_3  = 4'd3,
        TAG_MULT_1 = 4'd4,
        TAG_MULT_2 = 4'd5,
        TAG_LD_1   = 4'd6,
        TAG_LD_2   = 4'd7,
        TAG_LD_3   = 4'd8,
        TAG_ST_1   = 4'd9,
        TAG_ST_2   = 4'd10
    } rs_tag_e;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_MREQ  = 3'd2;
    localparam logic [2:0] ST_MWAIT = 3'd3;
    localparam logic [2:0] ST_CDB   = 3'd4;
    localparam logic [2:0] ST_FREE  = 3'd5;

    // last_sel value after reset, so that entry 0 is the first winner
    localparam logic [1:0] LAST_SEL_RST = 2'd2;

    // The ready bus is MSB-first: bit2 is entry 0, bit0 is entry 2
    function automatic logic ready_of(input logic [2:0] bus, input logic [1:0] idx);
        case (idx)
            2'd0:    ready_of = bus[2];
            2'd1:    ready_of = bus[1];
            2'd2:    ready_of = bus[0];
            default: ready_of = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ld_exec_sched_rr_arb3.sv
// Three-way round-robin arbiter. The search starts at the entry after
// 'last' and wraps; req uses the ready-bus bit order (bit2 = entry 0).
module rr_arb3
    import ld_exec_sched_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic r0_s;
    logic r1_s;
    logic r2_s;

    assign r0_s = ready_of(req, 2'd0);
    assign r1_s = ready_of(req, 2'd1);
    assign r2_s = ready_of(req, 2'd2);

    // Pick the first requesting entry following the previous winner
    always_comb begin
        gnt_idx = 2'd0;
        any     = r0_s | r1_s | r2_s;
        case (last)
            2'd0: begin
                if (r1_s)      gnt_idx = 2'd1;
                else if (r2_s) gnt_idx = 2'd2;
                else           gnt_idx = 2'd0;
            end
            2'd1: begin
                if (r2_s)      gnt_idx = 2'd2;
                else if (r0_s) gnt_idx = 2'd0;
                else           gnt_idx = 2'd1;
            end
            default: begin
                if (r0_s)      gnt_idx = 2'd0;
                else if (r1_s) gnt_idx = 2'd1;
                else           gnt_idx = 2'd2;
            end
        endcase
    end

endmodule

// File: rtl/ld_exec_sched.sv
// Load execution sequencer: picks a ready load entry, forms its effective
// address, performs one memory read, broadcasts the result on the CDB and
// frees the reservation entry. One load is in flight at a time.
module ld_exec_sched
    import ld_exec_sched_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int TAG_W   = 4,
    parameter int LD_TAG0 = int'(TAG_LD_1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        ready_bus,
    input  logic              ld_aff_ready,
    input  logic [DATA_W-1:0] ld_affinity_op,
    input  logic [DATA_W-1:0] ld_affinity_offset,
    output logic [TAG_W-1:0]  query_tag,
    output logic [DATA_W-1:0] address,
    output logic              free_tag_flag,
    output logic [TAG_W-1:0]  free_this_tag,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cdb_req,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_gnt,
    output logic              sched_busy
);

    // Tag of load entry idx
    function automatic logic [TAG_W-1:0] entry_tag(input logic [1:0] idx);
        entry_tag = TAG_W'(LD_TAG0) + TAG_W'(idx);
    endfunction

    logic [2:0]        state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        last_sel_q, last_sel_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

    logic [TAG_W-1:0]  query_tag_q, query_tag_d;
    logic              free_flag_q, free_flag_d;
    logic [TAG_W-1:0]  free_tag_q, free_tag_d;
    logic              mem_req_q, mem_req_d;
    logic              cdb_req_q, cdb_req_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic              busy_q, busy_d;

    logic [1:0]        arb_idx_s;
    logic              arb_any_s;
    logic [DATA_W-1:0] eff_addr_s;

    rr_arb3 u_arb (
        .req     (ready_bus),
        .last    (last_sel_q),
        .gnt_idx (arb_idx_s),
        .any     (arb_any_s)
    );

    // Effective address wraps modulo 2^DATA_W
    assign eff_addr_s = ld_affinity_op + ld_affinity_offset;

    // Address is only driven towards the station while it is being queried
    always_comb begin
        if (state_q == ST_ADDR) begin
            address = eff_addr_s;
        end else begin
            address = {DATA_W{1'b0}};
        end
    end

    // Next-state, selection and data-capture logic
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;
        mem_addr_d = mem_addr_q;
        cdb_data_d = cdb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any_s) begin
                    sel_d   = arb_idx_s;
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (ld_aff_ready) begin
                    mem_addr_d = eff_addr_s;
                    last_sel_d = sel_q;
                    state_d    = ST_MREQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MREQ: begin
                if (mem_ack && mem_rvalid) begin
                    cdb_data_d = mem_rdata;
                    state_d    = ST_CDB;
                end else if (mem_ack) begin
                    state_d = ST_MWAIT;
                end else begin
                    state_d = ST_MREQ;
                end
            end
            ST_MWAIT: begin
                if (mem_rvalid) begin
                    cdb_data_d = mem_rdata;
                    state_d    = ST_CDB;
                end else begin
                    state_d = ST_MWAIT;
                end
            end
            ST_CDB: begin
                if (cdb_gnt) begin
                    state_d = ST_FREE;
                end else begin
                    state_d = ST_CDB;
                end
            end
            ST_FREE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        query_tag_d = {TAG_W{1'b0}};
        free_flag_d = 1'b0;
        free_tag_d  = {TAG_W{1'b0}};
        mem_req_d   = 1'b0;
        cdb_req_d   = 1'b0;
        cdb_tag_d   = {TAG_W{1'b0}};
        busy_d      = (state_d != ST_IDLE);
        case (state_d)
            ST_ADDR: query_tag_d = entry_tag(sel_d);
            ST_MREQ: mem_req_d   = 1'b1;
            ST_CDB: begin
                cdb_req_d = 1'b1;
                cdb_tag_d = entry_tag(sel_d);
            end
            ST_FREE: begin
                free_flag_d = 1'b1;
                free_tag_d  = entry_tag(sel_d);
            end
            default: begin
                busy_d = (state_d != ST_IDLE);
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any in-flight load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'd0;
            last_sel_q  <= LAST_SEL_RST;
            mem_addr_q  <= {DATA_W{1'b0}};
            cdb_data_q  <= {DATA_W{1'b0}};
            query_tag_q <= {TAG_W{1'b0}};
            free_flag_q <= 1'b0;
            free_tag_q  <= {TAG_W{1'b0}};
            mem_req_q   <= 1'b0;
            cdb_req_q   <= 1'b0;
            cdb_tag_q   <= {TAG_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_sel_q  <= last_sel_d;
            mem_addr_q  <= mem_addr_d;
            cdb_data_q  <= cdb_data_d;
            query_tag_q <= query_tag_d;
            free_flag_q <= free_flag_d;
            free_tag_q  <= free_tag_d;
            mem_req_q   <= mem_req_d;
            cdb_req_q   <= cdb_req_d;
            cdb_tag_q   <= cdb_tag_d;
            busy_q      <= busy_d;
        end
    end

    assign query_tag     = query_tag_q;
    assign free_tag_flag = free_flag_q;
    assign free_this_tag = free_tag_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign cdb_req       = cdb_req_q;
    assign cdb_tag       = cdb_tag_q;
    assign cdb_data      = cdb_data_q;
    assign sched_busy    = busy_q;

endmodule

// File: tb/tb_ld_exec_sched.sv
// Self-checking bench for ld_exec_sched: directed scenarios with literal
// expectations plus a protocol-level model checked on every falling edge.
module tb_ld_exec_sched;

    logic        clk;
    logic        rst_n;
    logic [2:0]  ready_bus;
    logic        ld_aff_ready;
    logic [63:0] ld_affinity_op;
    logic [63:0] ld_affinity_offset;
    logic [3:0]  query_tag;
    logic [63:0] address;
    logic        free_tag_flag;
    logic [3:0]  free_this_tag;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        cdb_req;
    logic [3:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        cdb_gnt;
    logic        sched_busy;

    int total = 0;
    int bad   = 0;
    int freed_q[$];

    ld_exec_sched dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ready_bus          (ready_bus),
        .ld_aff_ready       (ld_aff_ready),
        .ld_affinity_op     (ld_affinity_op),
        .ld_affinity_offset (ld_affinity_offset),
        .query_tag          (query_tag),
        .address            (address),
        .free_tag_flag      (free_tag_flag),
        .free_this_tag      (free_this_tag),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_ack            (mem_ack),
        .mem_rvalid         (mem_rvalid),
        .mem_rdata          (mem_rdata),
        .cdb_req            (cdb_req),
        .cdb_tag            (cdb_tag),
        .cdb_data           (cdb_data),
        .cdb_gnt            (cdb_gnt),
        .sched_busy         (sched_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", nm, act, exp);
        end
    endtask

    // Round-robin reference: first ready entry after 'last' (bit2 = entry 0)
    function automatic int rr_pick(input int last, input logic [2:0] rb);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (last + k) % 3;
            if (rb[2 - idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait: 0 query, 1 mem_req, 2 cdb_req, 3 free pulse, 4 idle
    task automatic wait_for(input int which, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            case (which)
                0:       hit = (query_tag != 4'd0);
                1:       hit = mem_req;
                2:       hit = cdb_req;
                3:       hit = free_tag_flag;
                default: hit = !sched_busy;
            endcase
            if (hit) break;
            step();
        end
        chk({"wait_", nm}, 64'(hit), 64'd1);
    endtask

    // Protocol model: tracks one load from query to free on falling edges
    initial begin
        int          phase;      // 0 idle, 1 request, 2 wait data, 3 cdb, 4 free
        int          m_last;
        int          pick;
        int          cur_tag;
        logic [63:0] exp_addr;
        logic [63:0] exp_data;
        logic [2:0]  ready_prev;
        phase = 0; m_last = 2; cur_tag = 0; exp_addr = 64'd0; exp_data = 64'd0;
        ready_prev = 3'b000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_outs_zero", 64'(|{query_tag, address, free_tag_flag, free_this_tag,
                    mem_req, mem_addr, cdb_req, cdb_tag, cdb_data, sched_busy}), 64'd0);
                phase  = 0;
                m_last = 2;
            end else begin
                case (phase)
                    0: begin
                        chk("m_idle_busy", 64'(sched_busy), 64'(query_tag != 4'd0));
                        chk("m_idle_quiet", 64'(mem_req | cdb_req | free_tag_flag), 64'd0);
                        if (query_tag != 4'd0) begin
                            pick = rr_pick(m_last, ready_prev);
                            chk("m_pick", 64'(query_tag), 64'(6 + pick));
                            chk("m_address", address, ld_affinity_op + ld_affinity_offset);
                            cur_tag = 6 + pick;
                            if (ld_aff_ready) begin
                                m_last   = pick;
                                exp_addr = ld_affinity_op + ld_affinity_offset;
                                phase    = 1;
                            end
                        end
                    end
                    1: begin
                        chk("m_mem_req", 64'(mem_req), 64'd1);
                        chk("m_mem_addr", mem_addr, exp_addr);
                        chk("m_req_quiet", 64'(cdb_req | free_tag_flag | (query_tag != 4'd0)), 64'd0);
                        if (mem_ack && mem_rvalid) begin
                            exp_data = mem_rdata;
                            phase    = 3;
                        end else if (mem_ack) begin
                            phase = 2;
                        end
                    end
                    2: begin
                        chk("m_wait_quiet", 64'(mem_req | cdb_req | free_tag_flag), 64'd0);
                        chk("m_wait_busy", 64'(sched_busy), 64'd1);
                        if (mem_rvalid) begin
                            exp_data = mem_rdata;
                            phase    = 3;
                        end
                    end
                    3: begin
                        chk("m_cdb_req", 64'(cdb_req), 64'd1);
                        chk("m_cdb_tag", 64'(cdb_tag), 64'(cur_tag));
                        chk("m_cdb_data", cdb_data, exp_data);
                        chk("m_cdb_quiet", 64'(mem_req | free_tag_flag), 64'd0);
                        if (cdb_gnt) phase = 4;
                    end
                    default: begin
                        chk("m_free_flag", 64'(free_tag_flag), 64'd1);
                        chk("m_free_tag", 64'(free_this_tag), 64'(cur_tag));
                        chk("m_free_quiet", 64'(mem_req | cdb_req), 64'd0);
                        freed_q.push_back(int'(free_this_tag));
                        phase = 0;
                    end
                endcase
            end
            ready_prev = ready_bus;
        end
    end

    initial begin
        int n;
        int cnt;
        int base;
        rst_n = 1'b0; ready_bus = 3'b000; ld_aff_ready = 1'b0;
        ld_affinity_op = 64'd0; ld_affinity_offset = 64'd0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0; cdb_gnt = 1'b0;

        // T1: reset with all entries ready, then first pick is entry 0
        ready_bus = 3'b111;
        step(); step(); step();
        chk("t1_rst_busy", 64'(sched_busy), 64'd0);
        chk("t1_rst_query", 64'(query_tag), 64'd0);
        chk("t1_rst_memreq", 64'(mem_req), 64'd0);
        chk("t1_rst_cdbreq", 64'(cdb_req), 64'd0);
        rst_n = 1'b1;
        wait_for(0, "t1_query");
        chk("t1_first_pick", 64'(query_tag), 64'd6);
        ready_bus = 3'b000;
        wait_for(4, "t1_idle");

        // T2: entry 1 alone with a one-cycle-late slave
        ld_aff_ready = 1'b1; ld_affinity_op = 64'h1000; ld_affinity_offset = 64'h20;
        base = freed_q.size();
        ready_bus = 3'b010;
        wait_for(0, "t2_query");
        chk("t2_query_tag", 64'(query_tag), 64'd7);
        ready_bus = 3'b000;
        wait_for(1, "t2_mreq");
        chk("t2_mem_addr", mem_addr, 64'h1020);
        step(); mem_ack = 1'b1;
        step(); mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD;
        step(); mem_rvalid = 1'b0;
        chk("t2_cdb_req", 64'(cdb_req), 64'd1);
        chk("t2_cdb_tag", 64'(cdb_tag), 64'd7);
        chk("t2_cdb_data", cdb_data, 64'hDEAD);
        step(); cdb_gnt = 1'b1;
        step(); cdb_gnt = 1'b0;
        chk("t2_free_flag", 64'(free_tag_flag), 64'd1);
        chk("t2_free_tag", 64'(free_this_tag), 64'd7);
        step();
        chk("t2_free_once", 64'(free_tag_flag), 64'd0);
        step(); step();
        chk("t2_free_count", 64'(freed_q.size() - base), 64'd1);

        // T3: all ready continuously after reset, zero-wait slave
        rst_n = 1'b0; step(); rst_n = 1'b1;
        mem_ack = 1'b1; mem_rvalid = 1'b1; cdb_gnt = 1'b1; mem_rdata = 64'h55;
        freed_q.delete();
        ready_bus = 3'b111;
        cnt = 0;
        for (int i = 0; i < 80 && cnt < 4; i++) begin
            step();
            if (free_tag_flag) cnt++;
        end
        ready_bus = 3'b000;
        chk("t3_free_seen", 64'(cnt), 64'd4);
        repeat (8) step();
        chk("t3_free_total", 64'(freed_q.size()), 64'd4);
        if (freed_q.size() == 4) begin
            chk("t3_order0", 64'(freed_q[0]), 64'd6);
            chk("t3_order1", 64'(freed_q[1]), 64'd7);
            chk("t3_order2", 64'(freed_q[2]), 64'd8);
            chk("t3_order3", 64'(freed_q[3]), 64'd6);
        end

        // T4: best-case latency; the IDLE cycle is cycle 1, free is cycle 5
        ready_bus = 3'b001;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (n == 1) ready_bus = 3'b000;
            if (free_tag_flag) break;
        end
        chk("t4_free_after_pick", 64'(n + 1), 64'd5);
        wait_for(4, "t4_idle");

        // T5: address wrap, then an aborted query
        ld_affinity_op = 64'hFFFF_FFFF_FFFF_FFF0; ld_affinity_offset = 64'h20;
        ready_bus = 3'b100;
        wait_for(0, "t5_query");
        ready_bus = 3'b000;
        wait_for(1, "t5_mreq");
        chk("t5_wrap_addr", mem_addr, 64'h10);
        wait_for(4, "t5_idle");
        ld_aff_ready = 1'b0; base = freed_q.size();
        ready_bus = 3'b010;
        wait_for(0, "t5_abort_query");
        ready_bus = 3'b000;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_req || free_tag_flag || sched_busy) cnt++;
        end
        chk("t5_abort_quiet", 64'(cnt), 64'd0);
        chk("t5_abort_nofree", 64'(freed_q.size() - base), 64'd0);
        ld_aff_ready = 1'b1; ld_affinity_op = 64'h4000; ld_affinity_offset = 64'h8;
        ready_bus = 3'b111;
        wait_for(0, "t5_next_query");
        chk("t5_last_kept", 64'(query_tag), 64'd7);
        ready_bus = 3'b000;
        wait_for(4, "t5_done");

        // T6: reset while waiting for read data
        mem_ack = 1'b0; mem_rvalid = 1'b0; cdb_gnt = 1'b0;
        ready_bus = 3'b100;
        wait_for(0, "t6_query");
        chk("t6_query_tag", 64'(query_tag), 64'd6);
        ready_bus = 3'b000;
        wait_for(1, "t6_mreq");
        step(); mem_ack = 1'b1;
        step(); mem_ack = 1'b0;
        chk("t6_in_wait", 64'({mem_req, sched_busy}), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_abort_busy", 64'(sched_busy), 64'd0);
        chk("t6_abort_addr", mem_addr, 64'd0);
        chk("t6_abort_data", cdb_data, 64'd0);
        step(); rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hBEEF;
        step(); mem_rvalid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (cdb_req || sched_busy) cnt++;
            step();
        end
        chk("t6_no_cdb", 64'(cnt), 64'd0);
        ld_aff_ready = 1'b0;
        ready_bus = 3'b111;
        wait_for(0, "t6_requery");
        chk("t6_last_reset", 64'(query_tag), 64'd6);
        ready_bus = 3'b000;
        wait_for(4, "t6_idle");
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
